// File: rtl/rshift8_seq_pkg.sv
// Shared encodings for the rshift8_seq shifter: operation modes and FSM states.
package rshift8_seq_pkg;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_ASR = 2'b01,
        OP_ROR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/rshift8_seq_rsh1_step.sv
// Single-position right-shift slice and the 4:1 mux that selects its MSB fill.
module mx4 (
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic [1:0] sel,
    output logic       y
);
    always_comb begin
        y = a0;
        case (sel)
            2'b00:   y = a0;
            2'b01:   y = a1;
            2'b10:   y = a2;
            default: y = a3;
        endcase
    end
endmodule

module rsh1_step (
    input  logic [7:0] d,
    input  logic [1:0] op,
    output logic [7:0] q,
    output logic       cout
);
    logic fill;

    // Fill bit: zero for LSR and the reserved code, sign for ASR, wrapped LSB for ROR.
    mx4 u_fill (
        .a0  (1'b0),
        .a1  (d[7]),
        .a2  (d[0]),
        .a3  (1'b0),
        .sel (op),
        .y   (fill)
    );

    assign q    = {fill, d[7:1]};
    assign cout = d[0];
endmodule

// File: rtl/rshift8_seq.sv
// Sequential 8-bit right shifter: one bit position per clock, done pulse on completion.
module rshift8_seq
    import rshift8_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] shamt,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       carry,
    output logic       busy,
    output logic       done
);
    state_e     state;
    state_e     state_nxt;
    op_e        op_reg;
    logic [2:0] cnt;
    logic [7:0] step_q;
    logic       step_c;
    logic       accept;

    // A new request is only taken when not already shifting.
    assign accept = start && (state != ST_SHIFT);

    rsh1_step u_step (
        .d    (d_out),
        .op   (op_reg),
        .q    (step_q),
        .cout (step_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start)                 state_nxt = (shamt != 3'd0) ? ST_SHIFT : ST_DONE;
                else                       state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt == 3'd1)           state_nxt = ST_DONE;
            end
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out  <= 8'h00;
            carry  <= 1'b0;
            cnt    <= 3'd0;
            op_reg <= OP_LSR;
        end else if (accept) begin
            d_out  <= d_in;
            carry  <= 1'b0;
            cnt    <= shamt;
            op_reg <= op_e'(op);
        end else if (state == ST_SHIFT) begin
            d_out  <= step_q;
            carry  <= step_c;
            cnt    <= cnt - 3'd1;
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
endmodule

// File: tb/tb_rshift8_seq.sv
// Bench for rshift8_seq: directed cases with literal results plus randomized traffic checked every cycle.
module tb_rshift8_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [2:0] shamt = 3'd0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic       carry;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    // Transaction-level model: phase 0 idle, 1 shifting, 2 result pulse.
    int         m_phase = 0;
    int         m_k = 0;
    int         m_s = 0;
    logic [7:0] m_d = 8'h00;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_out = 8'h00;
    logic       m_carry = 1'b0;

    rshift8_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .shamt (shamt),
        .d_in  (d_in),
        .d_out (d_out),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Value after shifting d right by k positions in the given mode.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [1:0] o, input int k);
        logic signed [7:0] sd;
        logic [15:0]       dd;
        sd = d;
        dd = {d, d};
        case (o)
            2'b01:   return 8'(sd >>> k);
            2'b10:   return dd[k +: 8];
            default: return d >> k;
        endcase
    endfunction

    // The last bit out after k shifts is the original bit k-1 in every mode.
    function automatic logic ref_carry(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        return d[k-1];
    endfunction

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_out   <= 8'h00;
            m_carry <= 1'b0;
        end else if (m_phase != 1 && start) begin
            m_d     <= d_in;
            m_op    <= op;
            m_s     <= int'(shamt);
            m_k     <= 0;
            m_out   <= d_in;
            m_carry <= 1'b0;
            m_phase <= (shamt != 3'd0) ? 1 : 2;
        end else if (m_phase == 1) begin
            m_k     <= m_k + 1;
            m_out   <= ref_shift(m_d, m_op, m_k + 1);
            m_carry <= ref_carry(m_d, m_k + 1);
            m_phase <= (m_k + 1 == m_s) ? 2 : 1;
        end else if (m_phase == 2) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("cyc_d_out", d_out, m_out);
            check_output("cyc_carry", {7'd0, carry}, {7'd0, m_carry});
            check_output("cyc_busy", {7'd0, busy}, {7'd0, m_phase == 1});
            check_output("cyc_done", {7'd0, done}, {7'd0, m_phase == 2});
        end
    end

    // Issue one request from a negedge; returns on the negedge where done is seen.
    task automatic apply_stimulus(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s,
                                  input bit poke, input bit check_lit,
                                  input logic [7:0] exp_out, input logic exp_c);
        int cycles;
        start = 1'b1; op = o; d_in = d; shamt = s;
        @(negedge clk);
        start = 1'b0; op = $urandom_range(0, 3); d_in = $urandom; shamt = $urandom;
        cycles = 1;
        while (!done && cycles < 20) begin
            if (poke && cycles == 2) begin
                start = 1'b1; d_in = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_output("latency", 8'(cycles), 8'(int'(s) + 1));
        if (check_lit) begin
            check_output("lit_d_out", d_out, exp_out);
            check_output("lit_carry", {7'd0, carry}, {7'd0, exp_c});
        end
    endtask

    initial begin
        int gap;
        logic [1:0] ro;
        logic [7:0] rd;
        logic [2:0] rs;

        // Reset with start held high must not accept anything.
        start = 1'b1; d_in = 8'hAA; shamt = 3'd3;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check_output("rst_d_out", d_out, 8'h00);
        check_output("rst_carry", {7'd0, carry}, 8'h00);
        check_output("rst_busy", {7'd0, busy}, 8'h00);
        check_output("rst_done", {7'd0, done}, 8'h00);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);

        apply_stimulus(2'b00, 8'hB4, 3'd3, 1'b0, 1'b1, 8'h16, 1'b1);
        @(negedge clk);
        apply_stimulus(2'b01, 8'h90, 3'd2, 1'b0, 1'b1, 8'hE4, 1'b0);
        apply_stimulus(2'b10, 8'h81, 3'd1, 1'b0, 1'b1, 8'hC0, 1'b1);
        @(negedge clk);
        apply_stimulus(2'b00, 8'h5A, 3'd0, 1'b0, 1'b1, 8'h5A, 1'b0);
        @(negedge clk);
        apply_stimulus(2'b01, 8'h80, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        apply_stimulus(2'b00, 8'hFF, 3'd7, 1'b0, 1'b1, 8'h01, 1'b1);
        apply_stimulus(2'b11, 8'hC3, 3'd2, 1'b0, 1'b1, 8'h30, 1'b1);
        @(negedge clk);

        // Reset during the second SHIFT cycle discards the operation.
        start = 1'b1; op = 2'b10; d_in = 8'h0F; shamt = 3'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midrst_d_out", d_out, 8'h00);
        check_output("midrst_busy", {7'd0, busy}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("midrst_done", {7'd0, done}, 8'h00);
        end

        // Random traffic: the per-cycle model checks everything, the task checks latency and result.
        for (int n = 0; n < 300; n++) begin
            ro = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            apply_stimulus(ro, rd, rs, bit'($urandom_range(0, 1)), 1'b1,
                           ref_shift(rd, ro, int'(rs)), ref_carry(rd, int'(rs)));
            if (ro == 2'b10)
                check_output("ror_popcount", 8'($countones(d_out)), 8'($countones(rd)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
